// File: rtl/mc_pkg.sv
// mc_pkg
// Shared definitions for the multicycle datapath main controller:
//   - state_t  : controller state enumeration
//   - OP_*     : opcode constants decoded in DECODE / MEMADR
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU control encodings
//   - ctrl_t   : full control word produced for each state, including the
//                internal pcwrite / branch terms that are folded into pcen
// Optional feature macro: MC_CONTROLLER_JUMP_EN (JEX state is only entered
// when it is defined; the encoding is kept so the enum is identical in
// both builds).
package mc_pkg;

  localparam int OPW = 6;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  // All-zero control word: no enable asserted, every mux on its 0 input.
  function automatic ctrl_t ctrl_idle();
    return '0;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec
// Combinational decoder from controller state to the full control word.
// Ports:
//   state  in  state_t  current controller state
//   ctrl   out ctrl_t   control word for that state (pcwrite/branch still
//                       separate; the top combines them into pcen)
// Optional feature macro: MC_CONTROLLER_JUMP_EN (decodes JEX; without it
// JEX is treated like any other unreachable encoding).
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Moore output table. Every field starts at zero so each state only lists
  // what it asserts, and unreachable encodings produce an idle word.
  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      S_FETCH: begin
        ctrl.iord    = 1'b0;
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b0;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b0;
        ctrl.regwrite = 1'b1;
      end
`ifdef MC_CONTROLLER_JUMP_EN
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
`endif
      default: begin
        ctrl = ctrl_idle();
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Main control FSM of the multicycle datapath. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// enables and mux selects.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-low reset
//   op        in   opcode from the instruction register (used in DECODE
//                  and MEMADR only)
//   zero      in   ALU zero flag, used combinationally in BEQEX
//   pcen      out  PC enable = pcwrite | (branch & zero)
//   irwrite, regwrite, memwrite   out  storage write enables
//   iord, alusrca, alusrcb, aluop, pcsrc, regdst, memtoreg  out  selects
// While reset is low every output is forced to 0.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (adds the JEX state for
// op 000010; without it that opcode is illegal and pcsrc never reaches 10).
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  output logic           pcen,
  output logic           irwrite,
  output logic           regwrite,
  output logic           memwrite,
  output logic           iord,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           regdst,
  output logic           memtoreg
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  // State register; reset is sampled on the clock edge and returns to FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The opcode only matters in DECODE and MEMADR; any
  // unlisted or unreachable state falls back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_CONTROLLER_JUMP_EN
          OP_J:         state_d = S_JEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // Reset gating is combinational so that an in-flight write enable drops
  // in the very cycle reset goes low, not one edge later.
  always_comb begin
    ctrl = ctrl_raw;
    if (!reset) begin
      ctrl = ctrl_idle();
    end
  end

  assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign memwrite = ctrl.memwrite;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Scoreboarded bench for mc_controller. The driver issues one cycle at a
// time and pushes the control word expected for that cycle; a monitor
// process pops and compares on every falling edge.
// Control word layout used for comparison (14 bits):
//   {pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb[1:0],
//    aluop[1:0], pcsrc[1:0], regdst, memtoreg}
// Honours MC_CONTROLLER_JUMP_EN in the reference model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite, iord, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       regdst, memtoreg;

  typedef struct {
    logic [13:0] cw;
    string       tag;
  } exp_t;

  exp_t scoreQ[$];
  int   errors = 0;
  int   checks = 0;

  mc_controller #(.OPW(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .pcen     (pcen),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .memwrite (memwrite),
    .iord     (iord),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .pcsrc    (pcsrc),
    .regdst   (regdst),
    .memtoreg (memtoreg)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycles an instruction occupies, FETCH inclusive.
  function automatic int instrLen(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
`ifdef MC_CONTROLLER_JUMP_EN
      6'b000010: return 3;
`endif
      default:   return 2;
    endcase
  endfunction

  // Reference control word for cycle k (0 = FETCH) of an instruction with
  // opcode o, given the zero flag presented during that cycle.
  function automatic logic [13:0] expWord(input logic [5:0] o, input int k,
                                          input logic z);
    logic       ePcen, eIrw, eRegw, eMemw, eIord, eSrca, eRdst, eM2r;
    logic [1:0] eSrcb, eAluop, ePcsrc;
    ePcen = 0; eIrw = 0; eRegw = 0; eMemw = 0; eIord = 0; eSrca = 0;
    eRdst = 0; eM2r = 0; eSrcb = 2'b00; eAluop = 2'b00; ePcsrc = 2'b00;
    if (k == 0) begin
      eIrw = 1; ePcen = 1; eSrcb = 2'b01;
    end else if (k == 1) begin
      eSrcb = 2'b11;
    end else begin
      case (o)
        6'b100011: begin
          if (k == 2) begin eSrca = 1; eSrcb = 2'b10; end
          else if (k == 3) eIord = 1;
          else begin eM2r = 1; eRegw = 1; end
        end
        6'b101011: begin
          if (k == 2) begin eSrca = 1; eSrcb = 2'b10; end
          else begin eIord = 1; eMemw = 1; end
        end
        6'b000000: begin
          if (k == 2) begin eSrca = 1; eAluop = 2'b10; end
          else begin eRdst = 1; eRegw = 1; end
        end
        6'b001000: begin
          if (k == 2) begin eSrca = 1; eSrcb = 2'b10; end
          else eRegw = 1;
        end
        6'b000100: begin
          eSrca = 1; eAluop = 2'b01; ePcsrc = 2'b01; ePcen = z;
        end
        6'b000010: begin
          ePcsrc = 2'b10; ePcen = 1;
        end
        default: begin
          ePcen = 0;
        end
      endcase
    end
    return {ePcen, eIrw, eRegw, eMemw, eIord, eSrca, eSrcb, eAluop, ePcsrc,
            eRdst, eM2r};
  endfunction

  // Drive one cycle's inputs and record what the DUT should show for it.
  task automatic runCycle(input logic r, input logic [5:0] o, input logic z,
                          input logic [13:0] e, input string tag);
    exp_t ent;
    reset = r;
    op    = o;
    zero  = z;
    ent.cw  = e;
    ent.tag = tag;
    scoreQ.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  // One whole instruction. zMode: 0/1 forces zero, 2 randomises it.
  // abortAt >= 0 pulls reset low in that cycle and abandons the instruction.
  // The opcode is only held valid in DECODE and MEMADR; other cycles see
  // random garbage on op.
  task automatic applyStimulus(input logic [5:0] o, input int zMode,
                               input int abortAt, input string tag);
    int         len;
    logic [5:0] d;
    logic       z;
    len = instrLen(o);
    for (int k = 0; k < len; k++) begin
      d = (k == 1 || k == 2) ? o : 6'($urandom);
      z = (zMode == 2) ? 1'($urandom) : zMode[0];
      if (k == abortAt) begin
        runCycle(1'b0, d, z, 14'd0, $sformatf("%s_abort_c%0d", tag, k + 1));
        return;
      end
      runCycle(1'b1, d, z, expWord(o, k, z), $sformatf("%s_c%0d", tag, k + 1));
    end
  endtask

  // Compare one presented control word against the scoreboard entry.
  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    act = {pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb, aluop,
           pcsrc, regdst, memtoreg};
    checks++;
    if (act !== e.cw) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", e.tag, act, e.cw);
    end
  endtask

  // Monitor: the DUT presents a control word every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (scoreQ.size() > 0) begin
      checkOutput(scoreQ.pop_front());
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed cases first, then randomised instruction mix.
  initial begin
    logic [5:0] opTab [7];
    logic [5:0] o;
    int         abortAt;
    opTab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
              6'b000010, 6'b111111};
    reset = 1'b0;
    op    = 6'd0;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset phase");
    runCycle(1'b0, 6'($urandom), 1'b1, 14'd0, "reset_hold1");
    runCycle(1'b0, 6'($urandom), 1'b1, 14'd0, "reset_hold2");

    $display("[TB] directed instructions");
    applyStimulus(6'b100011, 2, -1, "lw");
    applyStimulus(6'b000100, 1, -1, "beq_z1");
    applyStimulus(6'b000100, 0, -1, "beq_z0");
    applyStimulus(6'b000000, 2, -1, "rtype");
    applyStimulus(6'b001000, 2, -1, "addi");
    applyStimulus(6'b000010, 2, -1, "j");
    applyStimulus(6'b111111, 2, -1, "illegal");
    applyStimulus(6'b101011, 2, -1, "sw");
    applyStimulus(6'b101011, 2, 3, "sw_memwr");
    applyStimulus(6'b100011, 2, -1, "lw_after_abort");

    $display("[TB] randomised instructions");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 7) o = 6'($urandom);
      else o = opTab[$urandom_range(0, 6)];
      abortAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      applyStimulus(o, 2, abortAt, $sformatf("rnd%0d_op%b", n, o));
    end

    for (int i = 0; i < 4 && scoreQ.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0",
               scoreQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
